uart_rx_core: RTL and testbench

Serial receiver for the FPGA UART link: recovers 8N1 frames from the `rx` pin using 16x oversampling and presents each byte as a one-cycle `data_valid` strobe. It is the receive half of the UART core and pairs with `uart_tx_core`: same baud rate, clock frequency, data width and stop-bit count, LSB-first framing. Downstream logic (command decoder / image-pixel loader) consumes `data_out` on the strobe; there is no backpressure.

---
 rtl/uart_rx_core.sv | 176 +++++++++++++++++
 tb/tb_uart_rx_core.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_core
//  Description : 8N1-style UART receiver, 16x oversampled, one-cycle strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core #(
   parameter int unsigned NO_OF_DATABITS = 8,
   parameter int unsigned NO_OF_STOPBITS = 1,
   parameter logic [31:0] BAUDRATE       = 32'd9600,
   parameter logic [31:0] FREQUENCY      = 32'd100000000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      rx,
   output logic [NO_OF_DATABITS-1:0] data_out,
   output logic                      data_valid,
   output logic                      framing_error,
   output logic                      busy
);

   localparam logic [31:0]        c_DIV       = FREQUENCY / (BAUDRATE * 32'd16);
   localparam int                 c_DIV_W     = (c_DIV > 32'd1) ? $clog2(c_DIV) : 1;
   localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(c_DIV - 32'd1);
   localparam int                 c_BCW       = (NO_OF_DATABITS > 1) ? $clog2(NO_OF_DATABITS + 1) : 1;
   localparam logic [c_BCW-1:0]   c_LAST_DATA = c_BCW'(NO_OF_DATABITS - 1);
   localparam logic [c_BCW-1:0]   c_LAST_STOP = c_BCW'(NO_OF_STOPBITS - 1);
   localparam logic [c_BCW-1:0]   c_BIT_ONE   = c_BCW'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t                    r_state;
   logic                      r_rx_meta;
   logic                      r_rx_sync;
   logic                      r_rx_prev;
   logic [c_DIV_W-1:0]        r_div;
   logic [3:0]                r_tick_cnt;
   logic [c_BCW-1:0]          r_bit_cnt;
   logic [NO_OF_DATABITS-1:0] r_shreg;
   logic                      r_stop_err;
   logic [NO_OF_DATABITS-1:0] r_data_out;
   logic                      r_data_valid;
   logic                      r_framing_error;
   logic                      r_busy;

   logic                      w_fall;
   logic                      w_tick;
   logic [NO_OF_DATABITS-1:0] w_shreg_next;

   // rx is asynchronous to clk; all three stages idle high like the line
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_sync <= r_rx_meta;
         r_rx_prev <= r_rx_sync;
      end
   end

   assign w_fall = r_rx_prev & ~r_rx_sync;

   always_ff @(posedge clk) begin
      if (reset || r_state == S_IDLE || w_tick) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + c_DIV_W'(1);
      end
   end

   assign w_tick = (r_div == c_DIV_LAST);

   generate
      if (NO_OF_DATABITS > 1) begin : g_shift_wide
         assign w_shreg_next = {r_rx_sync, r_shreg[NO_OF_DATABITS-1:1]};
      end else begin : g_shift_single
         assign w_shreg_next = r_rx_sync;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= S_IDLE;
         r_tick_cnt      <= '0;
         r_bit_cnt       <= '0;
         r_shreg         <= '0;
         r_stop_err      <= 1'b0;
         r_data_out      <= '0;
         r_data_valid    <= 1'b0;
         r_framing_error <= 1'b0;
         r_busy          <= 1'b0;
      end else begin
         r_data_valid    <= 1'b0;
         r_framing_error <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_fall) begin
                  r_state    <= S_START;
                  r_tick_cnt <= '0;
                  r_busy     <= 1'b1;
               end
            end
            S_START: begin
               if (w_tick) begin
                  if (r_tick_cnt == 4'd7) begin
                     r_tick_cnt <= '0;
                     if (!r_rx_sync) begin
                        r_state   <= S_DATA;
                        r_bit_cnt <= '0;
                     end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                     end
                  end else begin
                     r_tick_cnt <= r_tick_cnt + 4'd1;
                  end
               end
            end
            S_DATA: begin
               if (w_tick) begin
                  r_tick_cnt <= r_tick_cnt + 4'd1;
                  if (r_tick_cnt == 4'd15) begin
                     r_shreg <= w_shreg_next;
                     if (r_bit_cnt == c_LAST_DATA) begin
                        r_state    <= S_STOP;
                        r_bit_cnt  <= '0;
                        r_stop_err <= 1'b0;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + c_BIT_ONE;
                     end
                  end
               end
            end
            S_STOP: begin
               if (w_tick) begin
                  r_tick_cnt <= r_tick_cnt + 4'd1;
                  if (r_tick_cnt == 4'd15) begin
                     // Leaving at mid stop bit leaves half a bit to catch a zero-gap start edge
                     if (r_bit_cnt == c_LAST_STOP) begin
                        if (r_stop_err || !r_rx_sync) begin
                           r_framing_error <= 1'b1;
                        end else begin
                           r_data_out   <= r_shreg;
                           r_data_valid <= 1'b1;
                        end
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                     end else begin
                        r_stop_err <= r_stop_err | ~r_rx_sync;
                        r_bit_cnt  <= r_bit_cnt + c_BIT_ONE;
                     end
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign data_out      = r_data_out;
   assign data_valid    = r_data_valid;
   assign framing_error = r_framing_error;
   assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_core
//  Description : Scoreboard bench for uart_rx_core at 64 clk per bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;

   localparam int c_BIT = 64;
   localparam int c_LAT = 152 * 4 + 4;

   typedef struct {
      bit          err;
      logic [7:0]  data;
      int unsigned t0;
      bit          timed;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        rx;
   logic [7:0]  data_out;
   logic        data_valid;
   logic        framing_error;
   logic        busy;

   exp_t        sb[$];
   int unsigned cyc;
   int          n_checks;
   int          n_fail;
   logic [7:0]  last_good;

   uart_rx_core #(
      .NO_OF_DATABITS (8),
      .NO_OF_STOPBITS (1),
      .BAUDRATE       (32'd10000),
      .FREQUENCY      (32'd640000)
   ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .rx            (rx),
      .data_out      (data_out),
      .data_valid    (data_valid),
      .framing_error (framing_error),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Every strobe must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!reset && (data_valid || framing_error)) begin
         exp_t e;
         int unsigned lat;
         check_eq("strobe_exclusive", {31'd0, data_valid & framing_error}, 32'd0);
         if (sb.size() == 0) begin
            check_eq("unexpected_strobe", sb.size(), 32'd1);
         end else begin
            e = sb.pop_front();
            lat = cyc - e.t0;
            check_eq("strobe_kind", {31'd0, framing_error}, {31'd0, e.err});
            check_eq("data_out", {24'd0, data_out}, {24'd0, e.data});
            if (e.timed)
               check_eq("strobe_latency_window",
                        {31'd0, (lat + 2 >= c_LAT) && (lat <= c_LAT + 2)}, 32'd1);
         end
      end
   end

   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int bitlen,
                             input bit timed);
      exp_t e;
      e.err   = !stop_ok;
      e.data  = stop_ok ? b : last_good;
      e.t0    = cyc;
      e.timed = timed;
      sb.push_back(e);
      if (stop_ok) last_good = b;
      check_eq("busy_before_frame", {31'd0, busy}, 32'd0);
      rx = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("busy_not_yet", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check_eq("busy_rise", {31'd0, busy}, 32'd1);
      repeat (bitlen - 3) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (bitlen) @(negedge clk);
      end
      rx = stop_ok;
      repeat (bitlen) @(negedge clk);
      rx = 1'b1;
   endtask

   initial begin
      exp_t e;
      n_checks  = 0;
      n_fail    = 0;
      last_good = 8'h00;
      rx        = 1'b1;
      reset     = 1'b1;
      repeat (5) @(negedge clk);
      check_eq("rst_data_out", {24'd0, data_out}, 32'd0);
      check_eq("rst_data_valid", {31'd0, data_valid}, 32'd0);
      check_eq("rst_framing_error", {31'd0, framing_error}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;
      repeat (10) @(negedge clk);

      send_frame(8'h55, 1'b1, c_BIT, 1'b1);
      send_frame(8'hA3, 1'b1, c_BIT, 1'b1);
      repeat (3 * c_BIT) @(negedge clk);

      // Short low pulse: a glitch that must be rejected at mid start bit
      rx = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("glitch_busy_high", {31'd0, busy}, 32'd1);
      repeat (6) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      check_eq("glitch_busy_low", {31'd0, busy}, 32'd0);
      check_eq("glitch_data_kept", {24'd0, data_out}, {24'd0, last_good});
      repeat (c_BIT) @(negedge clk);

      send_frame(8'h3C, 1'b0, c_BIT, 1'b1);
      repeat (2 * c_BIT) @(negedge clk);
      check_eq("ferr_data_kept", {24'd0, data_out}, 32'h0000_00A3);

      // Break: 20 bit times low yields one framing error and no retrigger
      e.err = 1'b1; e.data = last_good; e.t0 = cyc; e.timed = 1'b0;
      sb.push_back(e);
      rx = 1'b0;
      repeat (20 * c_BIT) @(negedge clk);
      rx = 1'b1;
      repeat (2 * c_BIT) @(negedge clk);
      send_frame(8'h81, 1'b1, c_BIT, 1'b1);
      repeat (2 * c_BIT) @(negedge clk);

      // Reset pulse in the middle of data bit 4 of an 0xFF frame
      rx = 1'b0;
      repeat (c_BIT) @(negedge clk);
      rx = 1'b1;
      repeat (4 * c_BIT + 20) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("midframe_rst_data", {24'd0, data_out}, 32'd0);
      check_eq("midframe_rst_busy", {31'd0, busy}, 32'd0);
      last_good = 8'h00;
      repeat (5 * c_BIT) @(negedge clk);
      send_frame(8'h12, 1'b1, c_BIT, 1'b1);
      repeat (2 * c_BIT) @(negedge clk);
      check_eq("after_rst_data", {24'd0, data_out}, 32'h0000_0012);

      // Back-to-back stream with +/-3% baud offsets
      for (int i = 0; i < 24; i++) begin
         logic [7:0] b;
         int         bl;
         b  = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'($urandom_range(0, 255));
         bl = (i % 3 == 0) ? 62 : (i % 3 == 1) ? 64 : 66;
         send_frame(b, 1'b1, bl, bl == 64);
      end

      for (int k = 0; k < 2000 && sb.size() != 0; k++) @(negedge clk);
      check_eq("scoreboard_drained", sb.size(), 32'd0);
      repeat (c_BIT) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
